// File: rtl/network_acc_pkg.sv
// network_acc_pkg
// Shared definitions for the product accumulator / requantizer slice.
// Holds the default widths, the output fraction shift, the window length
// limit and the window state enum used by network_acc_requant.
// Ports: none (package).
package network_acc_pkg;

    localparam int DEF_IN_WIDTH   = 30;
    localparam int DEF_ACC_WIDTH  = 40;
    localparam int DEF_OUT_WIDTH  = 16;
    localparam int DEF_FRAC_SHIFT = 14;
    localparam int DEF_MAX_BEATS  = 1024;

    // S_FIRST: the next accepted beat opens a new window.
    // S_ACC:   a window is open and beats add into the running sum.
    typedef enum logic {
        S_FIRST = 1'b0,
        S_ACC   = 1'b1
    } acc_state_t;

endpackage

// File: rtl/network_acc_requant_sat.sv
// network_acc_requant_sat
// Combinational requantizer: rounds the accumulator half-up at the
// FRAC_SHIFT binary point, then clamps to the signed OUT_WIDTH range.
// Optional feature macro NETWORK_ACC_RELU_EN: when defined, negative
// clamped results are forced to zero.
// Ports:
//   acc_in  - signed accumulator value (ACC_WIDTH bits)
//   result  - signed rounded/saturated result (OUT_WIDTH bits)
module network_acc_requant_sat
    import network_acc_pkg::*;
#(
    parameter int ACC_WIDTH  = DEF_ACC_WIDTH,
    parameter int OUT_WIDTH  = DEF_OUT_WIDTH,
    parameter int FRAC_SHIFT = DEF_FRAC_SHIFT
) (
    input  logic signed [ACC_WIDTH-1:0] acc_in,
    output logic signed [OUT_WIDTH-1:0] result
);

    // One guard bit above the accumulator so adding the rounding half
    // can never wrap a value sitting at the top of the accumulator range.
    localparam int SW = ACC_WIDTH + 1;

    localparam logic signed [SW-1:0] HALF =
        {{(SW-FRAC_SHIFT){1'b0}}, 1'b1, {(FRAC_SHIFT-1){1'b0}}};
    localparam logic signed [SW-1:0] SAT_MAX =
        {{(SW-OUT_WIDTH+1){1'b0}}, {(OUT_WIDTH-1){1'b1}}};
    localparam logic signed [SW-1:0] SAT_MIN =
        {{(SW-OUT_WIDTH+1){1'b1}}, {(OUT_WIDTH-1){1'b0}}};

    logic signed [SW-1:0]        widened;
    logic signed [SW-1:0]        rounded;
    logic signed [OUT_WIDTH-1:0] clamped;

    // Round half-up by adding half an output LSB before the arithmetic
    // shift, then clamp anything outside the signed output range to the
    // nearest rail so large sums saturate instead of wrapping.
    always_comb begin
        widened = {acc_in[ACC_WIDTH-1], acc_in};
        rounded = (widened + HALF) >>> FRAC_SHIFT;
        if (rounded > SAT_MAX) begin
            clamped = SAT_MAX[OUT_WIDTH-1:0];
        end else if (rounded < SAT_MIN) begin
            clamped = SAT_MIN[OUT_WIDTH-1:0];
        end else begin
            clamped = rounded[OUT_WIDTH-1:0];
        end
    end

    // Optional rectification stage applied after saturation.
    always_comb begin
`ifdef NETWORK_ACC_RELU_EN
        result = clamped[OUT_WIDTH-1] ? '0 : clamped;
`else
        result = clamped;
`endif
    end

endmodule

// File: rtl/network_acc_requant.sv
// network_acc_requant
// Accumulates a window of signed products (AXI-stream style, delimited by
// prod_tlast), seeds each window with a bias aligned to the product binary
// point, and emits one requantized, saturated result per window with a
// single cycle of latency. A sticky flag reports windows longer than
// MAX_BEATS; accumulation keeps going after it is raised.
// Optional feature macro NETWORK_ACC_RELU_EN (see network_acc_requant_sat).
// Ports:
//   ap_clk       - clock, all state on the rising edge
//   ap_rst_n     - asynchronous active-low reset
//   prod_tdata   - signed product, IN_WIDTH bits
//   prod_tvalid  - product valid
//   prod_tlast   - last product of the window
//   prod_tready  - product accepted (combinational from the output stage)
//   bias_in      - signed bias, used on the first beat of a window
//   out_tdata    - signed requantized result, OUT_WIDTH bits
//   out_tvalid   - result valid
//   out_tready   - downstream ready
//   err_overrun  - sticky window-length error
module network_acc_requant
    import network_acc_pkg::*;
#(
    parameter int IN_WIDTH   = DEF_IN_WIDTH,
    parameter int ACC_WIDTH  = DEF_ACC_WIDTH,
    parameter int OUT_WIDTH  = DEF_OUT_WIDTH,
    parameter int FRAC_SHIFT = DEF_FRAC_SHIFT,
    parameter int MAX_BEATS  = DEF_MAX_BEATS
) (
    input  logic                        ap_clk,
    input  logic                        ap_rst_n,
    input  logic signed [IN_WIDTH-1:0]  prod_tdata,
    input  logic                        prod_tvalid,
    input  logic                        prod_tlast,
    output logic                        prod_tready,
    input  logic signed [OUT_WIDTH-1:0] bias_in,
    output logic signed [OUT_WIDTH-1:0] out_tdata,
    output logic                        out_tvalid,
    input  logic                        out_tready,
    output logic                        err_overrun
);

    localparam int CNT_WIDTH = $clog2(MAX_BEATS + 1);
    localparam logic [CNT_WIDTH-1:0] MAX_BEATS_CNT = CNT_WIDTH'(MAX_BEATS);

    // A full window of MAX_BEATS products needs IN_WIDTH + clog2(MAX_BEATS)
    // bits to hold its exact sum; refuse to build anything narrower.
    if (ACC_WIDTH < IN_WIDTH + $clog2(MAX_BEATS)) begin : g_acc_width_check
        $error("network_acc_requant: ACC_WIDTH too small for IN_WIDTH and MAX_BEATS");
    end

    acc_state_t                  state_q;
    acc_state_t                  state_d;
    logic signed [ACC_WIDTH-1:0] acc_q;
    logic signed [ACC_WIDTH-1:0] acc_next;
    logic signed [ACC_WIDTH-1:0] prod_ext;
    logic signed [ACC_WIDTH-1:0] bias_ext;
    logic [CNT_WIDTH-1:0]        beat_cnt_q;
    logic signed [OUT_WIDTH-1:0] sat_result;
    logic                        beat_fire;

    // A new product can be taken whenever the output register is empty or
    // is being drained this cycle, which gives full throughput.
    assign prod_tready = !out_tvalid || out_tready;
    assign beat_fire   = prod_tvalid && prod_tready;

    // Next accumulator value and next window state. The bias is moved up to
    // the product binary point so it only seeds the first beat of a window.
    always_comb begin
        prod_ext = {{(ACC_WIDTH-IN_WIDTH){prod_tdata[IN_WIDTH-1]}}, prod_tdata};
        bias_ext = {{(ACC_WIDTH-OUT_WIDTH){bias_in[OUT_WIDTH-1]}}, bias_in};
        state_d  = state_q;
        if (state_q == S_FIRST) begin
            acc_next = (bias_ext <<< FRAC_SHIFT) + prod_ext;
        end else begin
            acc_next = acc_q + prod_ext;
        end
        if (beat_fire) begin
            state_d = prod_tlast ? S_FIRST : S_ACC;
        end
    end

    network_acc_requant_sat #(
        .ACC_WIDTH  (ACC_WIDTH),
        .OUT_WIDTH  (OUT_WIDTH),
        .FRAC_SHIFT (FRAC_SHIFT)
    ) u_sat (
        .acc_in (acc_next),
        .result (sat_result)
    );

    // Window state register.
    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            state_q <= S_FIRST;
        end else begin
            state_q <= state_d;
        end
    end

    // Running accumulator, updated on every accepted beat.
    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            acc_q <= '0;
        end else if (beat_fire) begin
            acc_q <= acc_next;
        end
    end

    // Beats seen in the current window. The count parks at MAX_BEATS so an
    // over-long window keeps flagging without the counter wrapping; the
    // error flag is sticky until reset.
    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            beat_cnt_q  <= '0;
            err_overrun <= 1'b0;
        end else if (beat_fire) begin
            if (beat_cnt_q == MAX_BEATS_CNT) begin
                err_overrun <= 1'b1;
            end
            if (prod_tlast) begin
                beat_cnt_q <= '0;
            end else if (beat_cnt_q != MAX_BEATS_CNT) begin
                beat_cnt_q <= beat_cnt_q + 1'b1;
            end
        end
    end

    // Output register. A closing beat loads a fresh result (even while the
    // previous one is being taken); otherwise a downstream accept empties it.
    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            out_tvalid <= 1'b0;
            out_tdata  <= '0;
        end else if (beat_fire && prod_tlast) begin
            out_tvalid <= 1'b1;
            out_tdata  <= sat_result;
        end else if (out_tready) begin
            out_tvalid <= 1'b0;
        end
    end

endmodule
